// File: rtl/ws2812_frame_tx.sv
// WS2812 frame serializer: takes one NUM_PIXELS*24-bit frame and sends it as
// pulse-width symbols on a single data line, then holds the line low to latch.
module ws2812_frame_tx #(
  parameter int NUM_PIXELS   = 144,
  parameter int BIT_CYCLES   = 60,
  parameter int T0H_CYCLES   = 19,
  parameter int T1H_CYCLES   = 38,
  parameter int RESET_CYCLES = 14400
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PIXELS*24-1:0]   frame,
  input  logic                       frame_valid,
  output logic                       frame_ready,
  output logic                       dout,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int NBITS = NUM_PIXELS * 24;
  localparam int BW    = $clog2(NBITS);
  localparam int PW    = $clog2(BIT_CYCLES);
  localparam int LW    = $clog2(RESET_CYCLES + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(BIT_CYCLES - 1);
  localparam logic [PW-1:0] T0H_P    = PW'(T0H_CYCLES);
  localparam logic [PW-1:0] T1H_P    = PW'(T1H_CYCLES);
  localparam logic [LW-1:0] LAT_LAST = LW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t           state_q;
  logic [NBITS-1:0] sh_q;
  logic [BW-1:0]    bit_q;
  logic [PW-1:0]    phase_q;
  logic [LW-1:0]    lat_q;
  logic             dout_q, ready_q, busy_q, done_q;

  logic [NBITS-1:0] ord_d;
  logic [PW-1:0]    phase_d;

  // Reorder the frame into transmit order so the shifter only ever looks at bit 0.
  for (genvar p = 0; p < NUM_PIXELS; p++) begin : g_pix
    for (genvar b = 0; b < 24; b++) begin : g_bit
      assign ord_d[p*24 + b] = frame[p*24 + 23 - b];
    end
  end

  assign phase_d = phase_q + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      phase_q <= '0;
      lat_q   <= '0;
      dout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_valid && ready_q) begin
            state_q <= SEND;
            sh_q    <= ord_d;
            bit_q   <= '0;
            phase_q <= '0;
            dout_q  <= 1'b1;   // phase 0 is high for either symbol
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SEND: begin
          if (phase_q == PH_LAST) begin
            phase_q <= '0;
            if (bit_q == BIT_LAST) begin
              state_q <= LATCH;
              dout_q  <= 1'b0;
              lat_q   <= '0;
              done_q  <= (RESET_CYCLES == 1);
            end else begin
              bit_q  <= bit_q + BW'(1);
              sh_q   <= sh_q >> 1;
              dout_q <= 1'b1;
            end
          end else begin
            phase_q <= phase_d;
            dout_q  <= phase_d < (sh_q[0] ? T1H_P : T0H_P);
          end
        end
        LATCH: begin
          if (lat_q == LAT_LAST) begin
            state_q <= IDLE;
            lat_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            lat_q  <= lat_q + LW'(1);
            done_q <= (lat_q + LW'(1)) == LAT_LAST;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout        = dout_q;
  assign frame_ready = ready_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Randomized bench for ws2812_frame_tx against a cycle-indexed reference of the
// WS2812 waveform computed directly from the frame bits.
module tb_ws2812_frame_tx;

  localparam int NP  = 2;
  localparam int BC  = 6;
  localparam int T0H = 2;
  localparam int T1H = 4;
  localparam int RC  = 10;
  localparam int W   = NP * 24;
  localparam int NB  = NP * 24;
  localparam int TOT = NB * BC + RC;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] frame = '0;
  logic         frame_valid = 1'b0;
  logic         frame_ready, dout, busy, frame_done;

  int checks = 0;
  int errors = 0;

  ws2812_frame_tx #(
    .NUM_PIXELS(NP), .BIT_CYCLES(BC), .T0H_CYCLES(T0H),
    .T1H_CYCLES(T1H), .RESET_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .dout(dout), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    if (!(T0H > 0 && T0H < T1H && T1H < BC && RC >= 1 && NP >= 1))
      $fatal(1, "illegal parameter set");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level t cycles after the accept edge.
  function automatic logic ref_dout(input logic [W-1:0] f, input int t);
    int k, ph, pix, pb;
    if (t >= NB * BC) return 1'b0;
    k   = t / BC;
    ph  = t % BC;
    pix = k / 24;
    pb  = 23 - (k % 24);
    return ph < (f[pix*24 + pb] ? T1H : T0H);
  endfunction

  function automatic int ones(input logic [W-1:0] f);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(f[i]);
    return n;
  endfunction

  function automatic logic [W-1:0] rnd_frame();
    return {$urandom, $urandom};
  endfunction

  // Caller has frame/frame_valid driven with DUT idle; the next posedge accepts.
  task automatic run_frame(input logic [W-1:0] f, input logic [W-1:0] nxt,
                           input bit keep, input string tg);
    int hi = 0;
    int n1;
    @(posedge clk);
    #1;
    frame = nxt;
    frame_valid = keep;
    for (int t = 0; t <= TOT; t++) begin
      @(negedge clk);
      chk($sformatf("%s dout t=%0d", tg, t), dout, ref_dout(f, t));
      chk($sformatf("%s done t=%0d", tg, t), frame_done, t == TOT - 1);
      chk($sformatf("%s busy t=%0d", tg, t), busy, t < TOT);
      chk($sformatf("%s ready t=%0d", tg, t), frame_ready, t == TOT);
      if (t < NB * BC) hi += int'(dout);
    end
    n1 = ones(f);
    chk({tg, " high count"}, hi, n1 * T1H + (NB - n1) * T0H);
  endtask

  initial begin
    // Reset held with clock running.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst dout", dout, 0);
      chk("rst ready", frame_ready, 1);
      chk("rst busy", busy, 0);
      chk("rst done", frame_done, 0);
    end
    rst = 1'b1;

    // Directed single frame: pixel0 = 800001, pixel1 = 0.
    @(negedge clk);
    chk("idle ready", frame_ready, 1);
    frame = {24'h000000, 24'h800001};
    frame_valid = 1'b1;
    run_frame({24'h000000, 24'h800001}, rnd_frame(), 1'b0, "single");

    // All ones.
    frame = {W{1'b1}};
    frame_valid = 1'b1;
    run_frame({W{1'b1}}, rnd_frame(), 1'b0, "ones");

    // Back-to-back with valid held: B waits out A then is taken on the first IDLE edge.
    begin
      logic [W-1:0] fa, fb;
      fa = rnd_frame();
      fb = rnd_frame();
      frame = fa;
      frame_valid = 1'b1;
      run_frame(fa, fb, 1'b1, "b2bA");
      run_frame(fb, rnd_frame(), 1'b0, "b2bB");
    end

    // Async reset during bit 10 while dout is high.
    begin
      logic [W-1:0] fr;
      fr = rnd_frame();
      frame = fr;
      frame_valid = 1'b1;
      @(posedge clk);
      #1;
      frame_valid = 1'b0;
      for (int t = 0; t <= 10 * BC; t++) @(negedge clk);
      chk("pre-rst dout", dout, 1);
      #1;
      rst = 1'b0;
      #1;
      chk("async dout", dout, 0);
      chk("async ready", frame_ready, 1);
      chk("async busy", busy, 0);
      for (int i = 0; i < 3; i++) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < TOT + 5; i++) begin
        @(negedge clk);
        chk("post-rst done", frame_done, 0);
        chk("post-rst ready", frame_ready, 1);
      end
      fr = rnd_frame();
      frame = fr;
      frame_valid = 1'b1;
      run_frame(fr, rnd_frame(), 1'b0, "post-rst");
    end

    // Random frames with random idle gaps.
    for (int n = 0; n < 4; n++) begin
      logic [W-1:0] fr;
      int gap;
      gap = $urandom_range(0, 5);
      for (int i = 0; i < gap; i++) begin
        @(negedge clk);
        chk("gap ready", frame_ready, 1);
        chk("gap dout", dout, 0);
      end
      fr = rnd_frame();
      frame = fr;
      frame_valid = 1'b1;
      run_frame(fr, rnd_frame(), 1'b0, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_tx.md
Name: ws2812_frame_tx

Overview:
- Downstream serializer for the LED path.
- Accepts one full RGB frame (NUM_PIXELS × 24 bits) from the frame-rotation stage over a valid/ready handshake.
- Encodes every bit as a WS2812 pulse-width symbol on the single data line to the strip, then holds the line low for the latch (reset) interval.
- Reports frame completion so the upstream stage can advance its rotation pointer.

Parameters:
- NUM_PIXELS, 144: LEDs per frame; frame width is NUM_PIXELS*24.
- BIT_CYCLES, 60: clk cycles per encoded bit (1.25 us at 48 MHz).
- T0H_CYCLES, 19: high time of a '0' symbol, in cycles.
- T1H_CYCLES, 38: high time of a '1' symbol, in cycles.
- RESET_CYCLES, 14400: low latch interval after the last bit (300 us at 48 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- frame  in  NUM_PIXELS*24  pixel i at frame[i*24 +: 24], colour order as delivered.
- frame_valid  in  1  frame holds a frame to send.
- frame_ready  out  1  block can accept a frame this cycle.
- dout  out  1  WS2812 data line.
- busy  out  1  high from accept until frame_done inclusive.
- frame_done  out  1  one-cycle pulse at end of the latch interval.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, dout=0, frame_ready=1, busy=0, frame_done=0, internal frame copy and counters cleared. Any in-flight frame is dropped with no frame_done.
- Reset release is synchronous to clk; the first accept is possible on the first edge after release.
- Accept: on a clk edge with frame_valid && frame_ready, the whole frame is copied internally.
  - Upstream may change frame on the next cycle.
  - frame_ready is high only in IDLE.
- States:
  - IDLE -> SEND on accept.
  - SEND -> LATCH after the final cycle of the last bit.
  - LATCH -> IDLE after RESET_CYCLES cycles.
- SEND:
  - Bit order: pixel 0 first, pixel NUM_PIXELS-1 last; within a pixel, bit 23 first, bit 0 last. Total NUM_PIXELS*24 bits.
  - Per bit, a phase counter runs 0..BIT_CYCLES-1.
  - dout=1 while phase < (bit ? T1H_CYCLES : T0H_CYCLES), else 0.
  - Consecutive bits abut with no gap cycles.
- Latency: dout rises on the first cycle after the accept edge, which is phase 0 of bit 0.
- LATCH: dout=0 for exactly RESET_CYCLES cycles.
  - frame_done pulses for 1 cycle on the last LATCH cycle.
  - frame_ready returns high the following cycle (IDLE).
- Frame time: exactly NUM_PIXELS*24*BIT_CYCLES + RESET_CYCLES cycles from the accept edge to the IDLE entry edge.
- frame_valid during SEND/LATCH is ignored and never queued. A frame still valid when IDLE is re-entered is accepted on that first IDLE edge.
- dout is registered (glitch-free) and 0 in IDLE and LATCH.
- Counters:
  - Bit index is sized ceil(log2(NUM_PIXELS*24)).
  - Phase counter is sized ceil(log2(BIT_CYCLES)).
  - Latch counter is sized ceil(log2(RESET_CYCLES+1)).
  - None wraps outside its range.
- Legal parameters: 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES, RESET_CYCLES >= 1, NUM_PIXELS >= 1. Other values are unsupported; the bench flags them at elaboration.

Test Plan:
- Use NUM_PIXELS=2, BIT_CYCLES=6, T0H=2, T1H=4, RESET_CYCLES=10 unless stated.
- Reset values: hold rst=0 with clk running -> dout=0, frame_ready=1, busy=0, frame_done=0 every cycle.
- Single frame, pixel0=24'h800001, pixel1=24'h000000:
  - Bit 0 -> dout high 4 cycles, low 2.
  - Next 22 bits -> high 2, low 4.
  - Bit 23 -> high 4, low 2.
  - Pixel 1 -> 24 '0' symbols.
  - Then 10 low cycles. frame_done is high only at cycle 297 after the accept edge; frame_ready=1 at cycle 298.
- All-ones frame (48'hFFFF_FFFF_FFFF) -> dout high count=192 and low count=96 over 288 SEND cycles, then 10 LATCH lows. No idle gap between bits.
- Back-to-back: frame_valid held high with frame A then B -> A accepted at edge 0. B is not accepted during busy and is accepted on the edge after frame_done. B's first high on dout follows exactly 1 cycle after that edge.
- Async reset mid-frame: assert rst=0 during bit 10 while dout=1 -> dout=0 before the next clk edge. After release: frame_ready=1, no frame_done pulse, and a new frame transmits from bit 0 correctly.
- Default parameters, one frame with pixel 0 = 24'hFFFFFF, rest 0 -> first 24 bits have 38-cycle highs, the remaining 3432 bits have 19-cycle highs, the latch lasts 14400 cycles, and the frame totals 221760 cycles.
